mult_share_arbiter: RTL
=======================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one radix-4 Booth/Dadda multiplier (mult_top, 25x25 signed, 2-cycle latency) among N_REQ requesters.
//  Round-robin accepts at most one operand pair per cycle and tags it through the multiplier pipeline.
//  Each product is steered into that requester's response FIFO. Credit-based: a request is accepted only if its FIFO slot is guaranteed.
// PARAMETERS
//  N_REQ      4   number of requesters (2..8)
//  RSP_DEPTH  2   per-requester response FIFO depth = max outstanding (in-flight + queued) per requester (1..4)
// PORTS
//  clk        in   1            clock
//  rst_n      in   1            asynchronous active-low reset
//  req_valid  in   N_REQ        requester i has operands
//  req_ready  out  N_REQ        requester i accepted this cycle (valid&ready)
//  req_a      in   N_REQ*25     signed multiplicand, slice i = [25*i +: 25]
//  req_b      in   N_REQ*25     signed multiplier, slice i = [25*i +: 25]
//  rsp_valid  out  N_REQ        FIFO i head valid
//  rsp_ready  in   N_REQ        requester i pops head
//  rsp_p      out  N_REQ*50     signed product at FIFO i head, slice [50*i +: 50]
//  busy       out  1            any op in flight or any FIFO non-empty
// BEHAVIOUR
//  Reset: req_ready=0, rsp_valid=0, busy=0, rsp_p=0, credits=RSP_DEPTH, rr pointer=0, pipe valids=0, FIFOs empty.
//  Eligible(i) = req_valid[i] & credit[i]!=0. Grant = first eligible index at/after rr pointer (wrapping).
//  req_ready is combinational one-hot (or zero) = grant. It may depend on req_valid.
//  Accept at edge t: operands drive mult_top A/B inputs. rr pointer <= (granted+1) mod N_REQ. Pointer holds when no grant.
//  Tag pipe: stage1 {v,tag} loads at edge t, stage2 at edge t+1. Product write to FIFO[tag] at edge t+2.
//  rsp_valid rises after edge t+2: 3 cycles accept-to-response minimum, when the FIFO was empty.
//  Idle cycle: mult_top inputs are don't-care; stage1 v=0. mult_top has no reset; garbage is masked by the pipe valids.
//  credit[i]: -1 on accept, +1 on rsp pop. Both in the same cycle: unchanged. Never <0 or >RSP_DEPTH (assert).
//  FIFO overflow is impossible by construction (assert). Pop of an empty FIFO is ignored.
//  Write and pop in the same cycle on one FIFO are both legal, including on a full FIFO.
//  Per-requester responses stay in issue order. No ordering across requesters.
//  Product: rsp_p = A*B exact signed, 50 bits, no saturation. -2^24 * -2^24 = 2^48 is representable.
//  Full throughput: one accept every cycle while any requester is eligible.
//  Requester with credit 0: skipped without stalling others.
//  Reset mid-operation: in-flight products are discarded and FIFO contents dropped. All state returns to reset values immediately (async).
//  busy = stage1.v | stage2.v | any FIFO non-empty.
// STRUCTURE
//  Package mult_pkg holds A_W=25, P_W=50, MULT_LAT=2, and typedef tag_t = logic [$clog2(N_REQ)-1:0].
//  Sub-module mult_rsp_fifo (synchronous FIFO, DEPTH x P_W, async active-low reset) is instantiated N_REQ times.
//  One mult_top instance. RR arbiter, credit counters and tag pipe are inline.
// TESTING
//  1 Single op: req0 A=3,B=-5 accepted at edge t -> rsp_valid[0]=1 after edge t+2, rsp_p[0]=-15; busy low after pop.
//  2 Extremes: (-2^24,-2^24)->2^48; (2^24-1,-2^24)->-2^48+2^24; (0,-1)->0; (-1,-1)->1.
//  3 All 4 req_valid held, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle; all results correct and in order.
//  4 rsp_ready[1]=0, req1 always valid -> exactly 2 req1 accepts, then req_ready[1]=0 while req0/2/3 are still served.
//    Raise rsp_ready[1] -> results arrive in order, and the same-cycle pop+accept leaves credit at 1.
//  5 rst_n low with 2 ops in flight and 1 queued -> after release rsp_valid=0, busy=0, and a new req2 completes normally.
//  6 req1 only, rsp_ready[1] toggling randomly, 200 ops -> no loss or duplication; credit bounds asserts never fire.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared widths and types for the shared-multiplier arbiter slice.
package mult_pkg;
   localparam int A_W       = 25;
   localparam int P_W       = 50;
   localparam int MULT_LAT  = 2;
   localparam int N_REQ_MAX = 8;

   // Sized for the largest supported requester count so the package stays unparameterised.
   typedef logic [$clog2(N_REQ_MAX)-1:0] tag_t;

   typedef struct packed {
      logic v;
      tag_t tag;
   } pipe_t;
endpackage

// File: rtl/mult_rsp_fifo.sv
// Per-requester response FIFO; head data reads as zero while empty.
module mult_rsp_fifo
   import mult_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           wr_en,
   input  logic [P_W-1:0] wr_data,
   input  logic           rd_en,
   output logic           valid,
   output logic [P_W-1:0] rd_data
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [P_W-1:0] mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           pop;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
      return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
   endfunction

   assign valid   = (count != '0);
   assign pop     = rd_en & valid;
   assign rd_data = valid ? mem[rd_ptr] : '0;

   // NOTE: storage is not reset; count gates every read, so stale entries are never visible.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= next_ptr(wr_ptr);
         if (pop)   rd_ptr <= next_ptr(rd_ptr);
         case ({wr_en, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(wr_en && !pop && count == CW'(DEPTH)));
endmodule

// File: rtl/mult_top.sv
// 25x25 signed radix-4 Booth multiplier, inputs and product registered (2-cycle latency).
module mult_top
   import mult_pkg::*;
(
   input  logic                  clk,
   input  logic signed [A_W-1:0] a,
   input  logic signed [A_W-1:0] b,
   output logic signed [P_W-1:0] p
);
   localparam int NPP = (A_W + 1) / 2;

   logic signed [A_W-1:0] a_q, b_q;
   logic signed [P_W-1:0] sum;

   // NOTE: datapath registers carry no reset; validity is tracked by the tag pipe in the parent.
   always_ff @(posedge clk) begin
      a_q <= a;
      b_q <= b;
      p   <= sum;
   end

   // Booth digits recoded from overlapping bit triples; the compression tree is left to synthesis.
   always_comb begin
      logic signed [P_W-1:0] ax;
      logic signed [P_W-1:0] pp;
      logic [A_W+1:0]        bx;
      ax  = {{(P_W-A_W){a_q[A_W-1]}}, a_q};
      bx  = {b_q[A_W-1], b_q, 1'b0};
      sum = '0;
      for (int j = 0; j < NPP; j++) begin
         case (bx[2*j +: 3])
            3'b001, 3'b010: pp = ax;
            3'b011:         pp = ax <<< 1;
            3'b100:         pp = -(ax <<< 1);
            3'b101, 3'b110: pp = -ax;
            default:        pp = '0;
         endcase
         // NOTE: blocking assignments here build a combinational accumulation chain, not state.
         sum = sum + (pp <<< (2*j));
      end
   end
endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin, credit-gated sharing of one pipelined multiplier among N_REQ requesters.
module mult_share_arbiter
   import mult_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int RSP_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [N_REQ*A_W-1:0] req_a,
   input  logic [N_REQ*A_W-1:0] req_b,
   output logic [N_REQ-1:0]     rsp_valid,
   input  logic [N_REQ-1:0]     rsp_ready,
   output logic [N_REQ*P_W-1:0] rsp_p,
   output logic                 busy
);
   localparam int CW = $clog2(RSP_DEPTH + 1);

   tag_t                  ptr, gnt_idx;
   logic                  gnt_any;
   logic [N_REQ-1:0]      grant, eligible, pop, wr_en;
   logic [CW-1:0]         credit [N_REQ];
   pipe_t                 s1, s2;
   logic signed [A_W-1:0] mult_a, mult_b;
   logic signed [P_W-1:0] mult_p;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) eligible[i] = req_valid[i] && (credit[i] != '0);
   end

   // First eligible requester at or after the pointer, wrapping.
   always_comb begin
      int idx;
      grant   = '0;
      gnt_idx = ptr;
      gnt_any = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (!gnt_any && eligible[idx]) begin
            gnt_any    = 1'b1;
            gnt_idx    = tag_t'(idx);
            grant[idx] = 1'b1;
         end
      end
   end

   assign req_ready = grant;
   assign mult_a    = req_a[A_W*gnt_idx +: A_W];
   assign mult_b    = req_b[A_W*gnt_idx +: A_W];
   assign pop       = rsp_ready & rsp_valid;
   assign busy      = s1.v | s2.v | (|rsp_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
         s1  <= '0;
         s2  <= '0;
      end else begin
         if (gnt_any) ptr <= (gnt_idx == tag_t'(N_REQ - 1)) ? '0 : gnt_idx + tag_t'(1);
         s1 <= '{v: gnt_any, tag: gnt_idx};
         s2 <= s1;
      end
   end

   mult_top u_mult (
      .clk (clk),
      .a   (mult_a),
      .b   (mult_b),
      .p   (mult_p)
   );

   for (genvar i = 0; i < N_REQ; i++) begin : g_req
      assign wr_en[i] = s2.v && (s2.tag == tag_t'(i));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            credit[i] <= CW'(RSP_DEPTH);
         end else begin
            case ({grant[i], pop[i]})
               2'b10:   credit[i] <= credit[i] - CW'(1);
               2'b01:   credit[i] <= credit[i] + CW'(1);
               default: credit[i] <= credit[i];
            endcase
         end
      end

      a_credit_low: assert property (@(posedge clk) disable iff (!rst_n)
         !(grant[i] && !pop[i] && credit[i] == '0));
      a_credit_high: assert property (@(posedge clk) disable iff (!rst_n)
         !(pop[i] && !grant[i] && credit[i] == CW'(RSP_DEPTH)));

      mult_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_en   (wr_en[i]),
         .wr_data (mult_p),
         .rd_en   (rsp_ready[i]),
         .valid   (rsp_valid[i]),
         .rd_data (rsp_p[P_W*i +: P_W])
      );
   end
endmodule
